apb_master_arbiter: RTL and testbench
=====================================

# apb_master_arbiter

Shares one APB master port among NUM_REQ independent requesters (test sequencers, DMA-style agents, config loaders) in the peripheral subsystem. It picks requesters in round-robin order and runs each accepted request as a full APB SETUP/ACCESS transfer, honouring pready wait states. A watchdog aborts transfers whose slave never responds, and the result or error is returned to the granted requester.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 32, APB address width
- DATA_W, 32, APB data width
- TIMEOUT, 16, max ACCESS cycles before abort (>=2)

- pclk  in  1  APB clock; all logic on rising edge
- preset  in  1  reset, synchronous, active-high
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  one-hot acceptance pulse
- req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_write  in  NUM_REQ  1 = write
- req_wdata  in  NUM_REQ*DATA_W  packed write data
- rsp_valid  out  NUM_REQ  one-hot completion pulse, registered
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid
- rsp_err  out  1  timeout flag, valid with rsp_valid
- paddr, pwrite, pwdata  out  ADDR_W/1/DATA_W  APB request
- psel, penable  out  1  APB phase controls
- prdata  in  DATA_W; pready  in  1  APB completion

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: if any req_valid, the round-robin pick g starts its search at last_grant+1 with wrap. req_ready[g]=1 combinationally in this cycle. The block latches addr/write/wdata for g and last_grant<=g, then goes to SETUP. With no request it stays in IDLE.
- SETUP: psel=1, penable=0 for exactly one cycle, then ACCESS.
- ACCESS: psel=1, penable=1. Watchdog counts ACCESS cycles from 1.
  - pready=1: capture prdata (reads) or 0 (writes) into rsp_rdata. rsp_err=0. Go to IDLE.
  - pready=0 on the TIMEOUT-th ACCESS cycle: abort. rsp_rdata=0, rsp_err=1. Go to IDLE.
  - pready=1 on that same cycle counts as success, not timeout.
- rsp_valid[g] pulses for exactly one cycle in the cycle after completion or abort. rsp_rdata and rsp_err hold until the next response.
- Requesters hold req_valid and payload stable until req_ready. Retracting an unaccepted request is illegal.
- pwdata = latched wdata on writes, 0 on reads. paddr, pwrite and pwdata are stable from SETUP through the end of ACCESS.
- Reset values:
  - state=IDLE, psel=0, penable=0, paddr=0, pwrite=0, pwdata=0
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0
  - last_grant=NUM_REQ-1, so requester 0 has first priority
  - watchdog=0
- Reset asserted mid-transfer: psel and penable are 0 at the next edge. No rsp_valid is issued for the killed transfer, and the pointer returns to NUM_REQ-1.

## Timing
- Zero-wait slave: accept at cycle T, SETUP at T+1, ACCESS (pready=1) at T+2, rsp_valid and IDLE at T+3. The next accept is possible at T+3, giving 3 cycles per transfer.
- Each pready=0 cycle in ACCESS adds one cycle. A timeout response appears at T+2+TIMEOUT.
- psel never deasserts between SETUP and ACCESS of one transfer. psel is 0 in IDLE, so there is always at least one idle cycle between transfers.
- rsp_valid for a transfer and req_ready for the next may be in the same cycle.

## Structure
- Package apb_ctrl_pkg holds the state enum (IDLE/SETUP/ACCESS) and default width constants.
- Sub-module rr_arbiter (parameter N) has inputs req, last_grant and en. It outputs a one-hot grant and its index, and is purely combinational.
- Top level contains the FSM, payload latch, watchdog ($clog2(TIMEOUT+1) bits) and response registers.

## Test plan
- Single read, zero wait: req0 reads 0x1000, slave returns 0xCAFE_0001. Required: psel rises at T+1, penable at T+2, rsp_valid[0] at T+3 with rsp_rdata=0xCAFE_0001 and rsp_err=0.
- Write with 2 wait states: req1 writes 0xA5A5_A5A5 to 0x2004, pready low for 2 ACCESS cycles. Required: paddr and pwdata stable for all 4 psel cycles, rsp_valid[1] at T+5 with rsp_err=0.
- Contention: all four req_valid high from reset with zero-wait slave. Required: grant order 0,1,2,3,0, with req_ready pulses 3 cycles apart.
- Fairness: req0 and req2 continuously valid. Required: grants alternate 0,2,0,2 and never two consecutive grants to the same requester.
- Timeout with TIMEOUT=16: pready held 0. Required: abort after 16 ACCESS cycles, psel=0 in the next cycle, rsp_valid with rsp_err=1 and rsp_rdata=0. A second request then completes normally.
- Reset mid-ACCESS: assert preset during a waited transfer. Required: psel=penable=0 at the next edge and no rsp_valid. After release, a request from req3 with req0 also valid grants req0 first.

Source files
------------

// File: rtl/apb_ctrl_pkg.sv
// Shared types and default sizing for the APB master arbiter.
// Holds the transfer FSM state encoding and the default parameter values.
package apb_ctrl_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: search starts one past last_grant and wraps.
// Produces a one-hot grant plus its index; everything is zero when en is low.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  input  logic             en,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  int   cand_s;
  int   sum_s;
  logic found_s;

  // First requester after last_grant (in wrap order) wins
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found_s   = 1'b0;
    cand_s    = 0;
    sum_s     = 0;
    for (int k = 1; k <= N; k++) begin
      sum_s  = int'(last_grant) + k;
      cand_s = (sum_s >= N) ? (sum_s - N) : sum_s;
      if (en && !found_s && req[cand_s]) begin
        found_s        = 1'b1;
        grant[cand_s]  = 1'b1;
        grant_idx      = IDX_W'(cand_s);
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin APB master shared by NUM_REQ requesters.
// Runs SETUP/ACCESS transfers with pready wait states and a watchdog abort.
module apb_master_arbiter
  import apb_ctrl_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                      pclk,
  input  logic                      preset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [ADDR_W-1:0]         paddr,
  output logic                      pwrite,
  output logic [DATA_W-1:0]         pwdata,
  output logic                      psel,
  output logic                      penable,
  input  logic [DATA_W-1:0]         prdata,
  input  logic                      pready
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  apb_state_e           state_r;
  apb_state_e           state_nxt_s;
  logic [IDX_W-1:0]     last_grant_r;
  logic [NUM_REQ-1:0]   grant_s;
  logic [IDX_W-1:0]     grant_idx_s;
  logic                 arb_en_s;
  logic                 accept_s;
  logic                 timeout_s;
  logic                 done_s;
  logic [WD_W-1:0]      wdog_r;
  logic [ADDR_W-1:0]    paddr_r;
  logic                 pwrite_r;
  logic [DATA_W-1:0]    pwdata_r;
  logic                 psel_r;
  logic                 penable_r;
  logic [NUM_REQ-1:0]   rsp_valid_r;
  logic [DATA_W-1:0]    rsp_rdata_r;
  logic                 rsp_err_r;

  // Arbitration is only live while idle and out of reset, so req_ready reads 0 in reset
  assign arb_en_s = (state_r == IDLE) && !preset;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req        (req_valid),
    .last_grant (last_grant_r),
    .en         (arb_en_s),
    .grant      (grant_s),
    .grant_idx  (grant_idx_s)
  );

  assign accept_s  = |grant_s;
  assign timeout_s = (state_r == ACCESS) && !pready && (wdog_r == WD_W'(TIMEOUT));
  assign done_s    = (state_r == ACCESS) && (pready || timeout_s);

  // Next-state decode for the transfer FSM
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = SETUP;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SETUP: begin
        state_nxt_s = ACCESS;
      end
      ACCESS: begin
        if (done_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = ACCESS;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register with APB phase controls registered from the next state
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_r   <= IDLE;
      psel_r    <= 1'b0;
      penable_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      psel_r    <= (state_nxt_s != IDLE);
      penable_r <= (state_nxt_s == ACCESS);
    end
  end

  // Payload latch on acceptance; last_grant doubles as the owner of the live transfer
  always_ff @(posedge pclk) begin
    if (preset) begin
      paddr_r      <= '0;
      pwrite_r     <= 1'b0;
      pwdata_r     <= '0;
      last_grant_r <= IDX_W'(NUM_REQ - 1);
    end else if (accept_s) begin
      paddr_r      <= req_addr[grant_idx_s*ADDR_W +: ADDR_W];
      pwrite_r     <= req_write[grant_idx_s];
      pwdata_r     <= req_write[grant_idx_s] ? req_wdata[grant_idx_s*DATA_W +: DATA_W] : '0;
      last_grant_r <= grant_idx_s;
    end else begin
      paddr_r      <= paddr_r;
      pwrite_r     <= pwrite_r;
      pwdata_r     <= pwdata_r;
      last_grant_r <= last_grant_r;
    end
  end

  // Watchdog reads 1 on the first ACCESS cycle and never passes TIMEOUT
  always_ff @(posedge pclk) begin
    if (preset) begin
      wdog_r <= '0;
    end else if (state_nxt_s == ACCESS) begin
      if (state_r == ACCESS) begin
        wdog_r <= wdog_r + WD_W'(1);
      end else begin
        wdog_r <= WD_W'(1);
      end
    end else begin
      wdog_r <= '0;
    end
  end

  // Response registers: one-cycle valid pulse, data and error hold until the next response
  always_ff @(posedge pclk) begin
    if (preset) begin
      rsp_valid_r <= '0;
      rsp_rdata_r <= '0;
      rsp_err_r   <= 1'b0;
    end else if (done_s) begin
      rsp_valid_r <= {{(NUM_REQ-1){1'b0}}, 1'b1} << last_grant_r;
      rsp_rdata_r <= (pready && !pwrite_r) ? prdata : '0;
      rsp_err_r   <= !pready;
    end else begin
      rsp_valid_r <= '0;
      rsp_rdata_r <= rsp_rdata_r;
      rsp_err_r   <= rsp_err_r;
    end
  end

  assign req_ready = grant_s;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;
  assign paddr     = paddr_r;
  assign pwrite    = pwrite_r;
  assign pwdata    = pwdata_r;
  assign psel      = psel_r;
  assign penable   = penable_r;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Randomized bench for apb_master_arbiter against a timeline-level reference model.
// Each accepted transfer is scheduled by its wait count; every cycle's outputs are predicted.
module tb_apb_master_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic            pclk = 1'b0;
  logic            preset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_write;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic [AW-1:0]   paddr;
  logic            pwrite;
  logic [DW-1:0]   pwdata;
  logic            psel;
  logic            penable;
  logic [DW-1:0]   prdata;
  logic            pready;

  always #5 pclk = ~pclk;

  apb_master_arbiter #(
    .NUM_REQ (N),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .pclk      (pclk),
    .preset    (preset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_write (req_write),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .paddr     (paddr),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
    .psel      (psel),
    .penable   (penable),
    .prdata    (prdata),
    .pready    (pready)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // requester side of the model
  bit            pend[N];
  bit            gen_en[N];
  logic [AW-1:0] m_addr[N];
  bit            m_wr[N];
  logic [DW-1:0] m_wd[N];
  // transfer in flight
  bit            busy;
  int            t_acc, w, owner, last, cyc;
  logic [AW-1:0] x_addr;
  bit            x_wr;
  logic [DW-1:0] x_wd, x_rd;
  logic [DW-1:0] exp_rdata;
  bit            exp_err;
  // knobs
  int            gen_prob, wait_fixed;
  bit            rst_now, rd_fixed_en;
  logic [DW-1:0] rd_fixed;
  int            grant_q[$];
  int            tacc_q[$];

  function automatic int pick_wait();
    int r;
    if (wait_fixed >= 0) return wait_fixed;
    r = $urandom_range(99);
    if (r < 65) return $urandom_range(3);
    else if (r < 85) return $urandom_range(8, 4);
    else return $urandom_range(TO + 1, TO - 2);
  endfunction

  task automatic load(input int i, input logic [AW-1:0] a, input bit wr, input logic [DW-1:0] d);
    pend[i] = 1'b1; m_addr[i] = a; m_wr[i] = wr; m_wd[i] = d;
  endtask

  task automatic step();
    int c, end_c, g;
    bit e_psel, e_pen;
    logic [N-1:0] e_rsp, e_ready;
    @(negedge pclk);
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && gen_en[i] && ($urandom_range(99) < gen_prob))
        load(i, AW'($urandom), 1'($urandom_range(1)), DW'($urandom));
      req_valid[i]            = pend[i];
      req_addr[i*AW +: AW]    = m_addr[i];
      req_write[i]            = m_wr[i];
      req_wdata[i*DW +: DW]   = m_wd[i];
    end
    c     = cyc - t_acc;
    end_c = 2 + ((w < TO) ? w : TO - 1);
    prdata = rd_fixed_en ? rd_fixed : DW'($urandom);
    if (busy && c >= 2 && c <= end_c) pready = (c == 2 + w);
    else pready = 1'($urandom_range(1));
    if (busy && c == 2 + w && w < TO) x_rd = x_wr ? '0 : prdata;
    preset = rst_now;
    #1;
    e_psel = busy && c >= 1 && c <= end_c;
    e_pen  = busy && c >= 2 && c <= end_c;
    check_eq("psel", psel, e_psel);
    check_eq("penable", penable, e_pen);
    if (e_psel) begin
      check_eq("paddr", paddr, x_addr);
      check_eq("pwrite", pwrite, x_wr);
      check_eq("pwdata", pwdata, x_wr ? x_wd : '0);
    end
    e_rsp = '0;
    if (busy && c == end_c + 1) begin
      e_rsp[owner] = 1'b1;
      exp_rdata    = (w < TO) ? x_rd : '0;
      exp_err      = (w >= TO);
      busy         = 1'b0;
    end
    check_eq("rsp_valid", rsp_valid, e_rsp);
    check_eq("rsp_rdata", rsp_rdata, exp_rdata);
    check_eq("rsp_err", rsp_err, exp_err);
    e_ready = '0;
    g = -1;
    if (!busy && !rst_now)
      for (int k = 1; k <= N; k++)
        if (g < 0 && pend[(last + k) % N]) g = (last + k) % N;
    if (g >= 0) e_ready[g] = 1'b1;
    check_eq("req_ready", req_ready, e_ready);
    if (rst_now) begin
      busy = 1'b0; last = N - 1; exp_rdata = '0; exp_err = 1'b0;
    end else if (g >= 0) begin
      busy = 1'b1; t_acc = cyc; owner = g; last = g;
      x_addr = m_addr[g]; x_wr = m_wr[g]; x_wd = m_wd[g];
      w = pick_wait(); pend[g] = 1'b0;
      grant_q.push_back(g); tacc_q.push_back(cyc);
    end
    cyc++;
  endtask

  initial begin
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    preset = 1'b1; req_valid = '1; req_addr = '0; req_write = '0; req_wdata = '0;
    pready = 1'b0; prdata = '0;
    busy = 1'b0; last = N - 1; cyc = 0; t_acc = 0; w = 0; owner = 0;
    exp_rdata = '0; exp_err = 1'b0; x_rd = '0;
    gen_prob = 0; wait_fixed = -1; rst_now = 1'b1; rd_fixed_en = 1'b0; rd_fixed = '0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; gen_en[i] = 1'b1; m_addr[i] = '0; m_wr[i] = 1'b0; m_wd[i] = '0;
    end
    repeat (3) @(negedge pclk);
    #1;
    check_eq("rst_psel", psel, 1'b0);
    check_eq("rst_penable", penable, 1'b0);
    check_eq("rst_paddr", paddr, '0);
    check_eq("rst_pwrite", pwrite, 1'b0);
    check_eq("rst_pwdata", pwdata, '0);
    check_eq("rst_req_ready", req_ready, '0);
    check_eq("rst_rsp_valid", rsp_valid, '0);
    check_eq("rst_rsp_rdata", rsp_rdata, '0);
    check_eq("rst_rsp_err", rsp_err, 1'b0);
    step();
    rst_now = 1'b0;

    // contention: all four valid straight out of reset, zero-wait slave
    for (int i = 0; i < N; i++) load(i, AW'($urandom), 1'($urandom_range(1)), DW'($urandom));
    gen_prob = 100; wait_fixed = 0;
    grant_q.delete(); tacc_q.delete();
    repeat (16) step();
    for (int k = 0; k < 5; k++) check_eq("cont_order", grant_q[k], exp_order[k]);
    for (int k = 1; k < 5; k++) check_eq("cont_spacing", tacc_q[k] - tacc_q[k-1], 3);
    gen_prob = 0;
    repeat (24) step();

    // single zero-wait read
    rd_fixed_en = 1'b1; rd_fixed = 32'hCAFE_0001;
    load(0, 32'h0000_1000, 1'b0, 32'h0);
    repeat (6) step();
    check_eq("rd_data", rsp_rdata, 32'hCAFE_0001);
    check_eq("rd_err", rsp_err, 1'b0);
    rd_fixed_en = 1'b0;

    // write with two wait states
    wait_fixed = 2;
    load(1, 32'h0000_2004, 1'b1, 32'hA5A5_A5A5);
    repeat (8) step();
    check_eq("wr_err", rsp_err, 1'b0);
    check_eq("wr_rdata", rsp_rdata, 32'h0);

    // fairness between requesters 0 and 2
    gen_en[1] = 1'b0; gen_en[3] = 1'b0; gen_prob = 100; wait_fixed = 1;
    grant_q.delete();
    repeat (60) step();
    check_eq("fair_count", grant_q.size() >= 10, 1'b1);
    for (int k = 1; k < grant_q.size(); k++)
      check_eq("fair_alt", grant_q[k] != grant_q[k-1], 1'b1);
    gen_prob = 0;
    repeat (12) step();
    gen_en[1] = 1'b1; gen_en[3] = 1'b1;

    // slave answers on the last allowed ACCESS cycle: success
    wait_fixed = TO - 1;
    load(0, AW'($urandom), 1'b0, '0);
    repeat (TO + 4) step();
    check_eq("edge_err", rsp_err, 1'b0);

    // slave never answers: abort, then a normal transfer
    wait_fixed = TO + 5;
    load(2, AW'($urandom), 1'b0, '0);
    repeat (TO + 4) step();
    check_eq("to_err", rsp_err, 1'b1);
    check_eq("to_rdata", rsp_rdata, '0);
    wait_fixed = 0;
    load(3, AW'($urandom), 1'b0, '0);
    repeat (5) step();
    check_eq("after_to_err", rsp_err, 1'b0);

    // reset in the middle of a waited ACCESS
    wait_fixed = 10;
    load(1, AW'($urandom), 1'b1, DW'($urandom));
    repeat (5) step();
    load(0, AW'($urandom), 1'b0, '0);
    load(3, AW'($urandom), 1'b0, '0);
    rst_now = 1'b1;
    step();
    rst_now = 1'b0;
    wait_fixed = 0;
    grant_q.delete();
    repeat (12) step();
    check_eq("rst_first", grant_q[0], 0);
    check_eq("rst_second", grant_q[1], 3);

    // random traffic with occasional resets
    wait_fixed = -1; gen_prob = 35;
    repeat (3000) begin
      rst_now = ($urandom_range(599) == 0);
      step();
    end
    rst_now = 1'b0; gen_prob = 0;
    repeat (60) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
